// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the data cache.
// Used by the miss controller and by the tag array.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL,
        INSTALL
    } state_t;

    function automatic int calc_off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int calc_tag_w(
        input int addr_w,
        input int index_w,
        input int words
    );
        return addr_w - index_w - $clog2(words) - 2;
    endfunction

    // Field slices are returned as LSB positions so callers keep native widths
    function automatic int off_lsb();
        return 2;
    endfunction

    function automatic int index_lsb(input int off_w);
        return off_w + 2;
    endfunction

    function automatic int tag_lsb(input int index_w, input int off_w);
        return index_w + off_w + 2;
    endfunction

endpackage

// File: rtl/dcache_beat_cnt.sv
// Word-beat counter for line transfers: clear, ack-enable,
// terminal-count flag.
module dcache_beat_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = &cnt;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Blocking D-cache miss handler: dirty victim writeback, word-serial
// refill and tag install while holding the pipeline stall.
module dcache_miss_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int WORDS   = 4,
    parameter int INDEX_W = 6,
    localparam int OFF_W  = calc_off_w(WORDS),
    localparam int TAG_W  = calc_tag_w(ADDR_W, INDEX_W, WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_MemEnable,
    input  logic              i_RW_MEM,
    input  logic [ADDR_W-1:0] i_Addr,
    input  logic              i_Hit,
    input  logic              i_VictimDirty,
    input  logic [TAG_W-1:0]  i_VictimTag,
    output logic              o_DCache_Miss,
    output logic              o_Mem_Req,
    output logic              o_Mem_We,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [DATA_W-1:0] o_Mem_WData,
    input  logic              i_Mem_Ack,
    input  logic [DATA_W-1:0] i_Mem_RData,
    output logic [OFF_W-1:0]  o_Arr_Word,
    input  logic [DATA_W-1:0] i_Arr_RData,
    output logic              o_Arr_WE,
    output logic [DATA_W-1:0] o_Arr_WData,
    output logic              o_Tag_WE
);

    localparam int IDX_LSB = index_lsb(OFF_W);
    localparam int TAG_LSB = tag_lsb(INDEX_W, OFF_W);

    state_t             state;
    logic [TAG_W-1:0]   line_tag;
    logic [TAG_W-1:0]   vic_tag;
    logic [INDEX_W-1:0] line_idx;
    logic [OFF_W-1:0]   cnt;
    logic               cnt_last;
    logic               start;
    logic               busy;
    logic               beat;
    logic               unused_bits;

    // Loads and stores allocate alike; the word offset only matters on the hit path
    assign unused_bits = ^{i_RW_MEM, i_Addr[IDX_LSB-1:0]};

    assign start = (state == IDLE) & i_MemEnable & ~i_Hit;
    assign busy  = (state == WB) | (state == REFILL);
    assign beat  = busy & i_Mem_Ack;

    dcache_beat_cnt #(
        .W(OFF_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .en   (beat),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            line_tag <= '0;
            vic_tag  <= '0;
            line_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        line_tag <= i_Addr[TAG_LSB +: TAG_W];
                        line_idx <= i_Addr[IDX_LSB +: INDEX_W];
                        vic_tag  <= i_VictimTag;
                        state    <= i_VictimDirty ? WB : REFILL;
                    end
                end
                WB: begin
                    if (beat && cnt_last) state <= REFILL;
                end
                REFILL: begin
                    if (beat && cnt_last) state <= INSTALL;
                end
                INSTALL: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_DCache_Miss = (state != IDLE) | (i_MemEnable & ~i_Hit);
        o_Mem_Req     = busy;
        o_Mem_We      = (state == WB);
        o_Mem_Addr    = '0;
        o_Mem_WData   = '0;
        o_Arr_Word    = '0;
        o_Arr_WE      = 1'b0;
        o_Arr_WData   = '0;
        o_Tag_WE      = (state == INSTALL);
        if (busy) begin
            o_Mem_Addr = {(state == WB) ? vic_tag : line_tag,
                          line_idx, cnt, 2'b00};
            o_Arr_Word = cnt;
        end
        if (state == WB) begin
            o_Mem_WData = i_Arr_RData;
        end
        if (state == REFILL && i_Mem_Ack) begin
            o_Arr_WE    = 1'b1;
            o_Arr_WData = i_Mem_RData;
        end
    end

endmodule
